// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide memory between the fetch unit (read-only)
// and the load/store unit. Each 16-bit word access becomes two byte cycles,
// big-endian, with round-robin arbitration on simultaneous requests.
//
// state | meaning
// IDLE  | no access in flight, sample requests and pick an owner
// B0    | memory cycle for the high byte at addr
// B1    | memory cycle for the low byte at addr+1, high read byte arrives
// CAP   | memory idle, low read byte arrives
// ACK   | owner's ack pulse, read word presented
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int BYTE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_ack,
    output logic [2*BYTE_W-1:0]   if_rdata,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_W-1:0]     ls_addr,
    input  logic [2*BYTE_W-1:0]   ls_wdata,
    output logic                  ls_ack,
    output logic [2*BYTE_W-1:0]   ls_rdata,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [BYTE_W-1:0]     mem_wdata,
    input  logic [BYTE_W-1:0]     mem_rdata,
    output logic                  mem_we,
    output logic                  mem_cs,
    output logic                  busy
);

    localparam int WORD_W = 2 * BYTE_W;

    typedef enum logic [2:0] {IDLE, B0, B1, CAP, ACK} state_t;
    typedef enum logic {OWN_IF, OWN_LS} owner_t;

    state_t              state, state_n;
    owner_t              owner, owner_n;
    owner_t              last_grant, last_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic                we_q, we_n;
    logic [WORD_W-1:0]   wdata_q, wdata_n;
    logic [BYTE_W-1:0]   hi_byte;
    logic                pick_ls;

    logic                cs_n;
    logic                mwe_n;
    logic [ADDR_W-1:0]   maddr_n;
    logic [BYTE_W-1:0]   mwdata_n;
    logic [WORD_W-1:0]   word_n;

    // Next-state, grant decision and next values of the registered memory pins.
    always_comb begin
        state_n  = state;
        owner_n  = owner;
        last_n   = last_grant;
        addr_n   = addr_q;
        we_n     = we_q;
        wdata_n  = wdata_q;
        pick_ls  = 1'b0;

        unique case (state)
            IDLE: begin
                if (if_req || ls_req) begin
                    // Contention goes to whoever did not win last time.
                    pick_ls = ls_req && (!if_req || (last_grant == OWN_IF));
                    owner_n = pick_ls ? OWN_LS : OWN_IF;
                    last_n  = owner_n;
                    addr_n  = pick_ls ? ls_addr : if_addr;
                    we_n    = pick_ls && ls_we;
                    wdata_n = pick_ls ? ls_wdata : '0;
                    state_n = B0;
                end
            end
            B0:      state_n = B1;
            B1:      state_n = CAP;
            CAP:     state_n = ACK;
            ACK:     state_n = IDLE;
            default: state_n = IDLE;
        endcase

        cs_n     = (state_n == B0) || (state_n == B1);
        mwe_n    = cs_n && we_n;
        maddr_n  = (state_n == B1) ? addr_n + ADDR_W'(1) : addr_n;
        mwdata_n = (state_n == B1) ? wdata_n[BYTE_W-1:0] : wdata_n[WORD_W-1:BYTE_W];
        word_n   = {hi_byte, mem_rdata};
    end

    // State, latched request, memory pins, read capture and ack registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            last_grant <= OWN_LS;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            hi_byte    <= '0;
            mem_cs     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ack     <= 1'b0;
            ls_ack     <= 1'b0;
            if_rdata   <= '0;
            ls_rdata   <= '0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_grant <= last_n;
            addr_q     <= addr_n;
            we_q       <= we_n;
            wdata_q    <= wdata_n;
            mem_cs     <= cs_n;
            mem_we     <= mwe_n;
            mem_addr   <= maddr_n;
            mem_wdata  <= mwdata_n;

            if ((state == B1) && !we_q)
                hi_byte <= mem_rdata;

            if_ack <= (state == CAP) && (owner == OWN_IF);
            ls_ack <= (state == CAP) && (owner == OWN_LS);

            if ((state == CAP) && !we_q) begin
                if (owner == OWN_IF)
                    if_rdata <= word_n;
                else
                    ls_rdata <= word_n;
            end
        end
    end

    // Busy whenever an access is in flight.
    always_comb begin
        busy = (state != IDLE);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus for mem_arbiter with a byte memory model
// and a scoreboard monitor that checks every ack against queued expectations.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ack;
    logic [15:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [15:0] ls_addr;
    logic [15:0] ls_wdata;
    logic        ls_ack;
    logic [15:0] ls_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_we;
    logic        mem_cs;
    logic        busy;

    logic        bd_we;
    logic [15:0] bd_addr;
    logic [7:0]  bd_data;
    logic [7:0]  mem [0:65535];

    int errors = 0;
    int checks = 0;
    int we_cycles = 0;

    typedef struct packed {
        logic        we;
        logic [15:0] data;
    } exp_t;

    exp_t if_q[$];
    exp_t ls_q[$];
    logic order_q[$];      // 0 = IF, 1 = LS; only filled for the contention run

    logic [15:0] if_last, ls_last;
    logic        prev_if_ack, prev_ls_ack;

    mem_arbiter #(.ADDR_W(16), .BYTE_W(8)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ack(ls_ack), .ls_rdata(ls_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_cs(mem_cs), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous byte memory with a backdoor write port for preloading.
    always @(posedge clk) begin
        if (bd_we)
            mem[bd_addr] <= bd_data;
        else if (mem_cs && mem_we)
            mem[mem_addr] <= mem_wdata;
        if (mem_cs && !mem_we)
            mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every ack and watches protocol rules.
    initial begin
        exp_t e;
        logic o;
        if_last = '0;
        ls_last = '0;
        prev_if_ack = 1'b0;
        prev_ls_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if_last = '0;
                ls_last = '0;
            end
            if (mem_we) we_cycles++;
            if (mem_we && !mem_cs) check("we_without_cs", 32'(mem_cs), 32'd1);
            if (if_ack && ls_ack) check("double_ack", 32'(ls_ack), 32'd0);
            if (if_ack) begin
                check("if_ack_pulse", 32'(prev_if_ack), 32'd0);
                if (if_q.size() == 0) begin
                    check("if_unexpected_ack", 32'(if_ack), 32'd0);
                end else begin
                    e = if_q.pop_front();
                    check("if_rdata", 32'(if_rdata), 32'(e.data));
                    if_last = if_rdata;
                end
                if (order_q.size() != 0) begin
                    o = order_q.pop_front();
                    check("grant_order_if", 32'd0, 32'(o));
                end
            end
            if (ls_ack) begin
                check("ls_ack_pulse", 32'(prev_ls_ack), 32'd0);
                if (ls_q.size() == 0) begin
                    check("ls_unexpected_ack", 32'(ls_ack), 32'd0);
                end else begin
                    e = ls_q.pop_front();
                    if (e.we)
                        check("ls_rdata_store_hold", 32'(ls_rdata), 32'(ls_last));
                    else
                        check("ls_rdata", 32'(ls_rdata), 32'(e.data));
                    ls_last = ls_rdata;
                end
                if (order_q.size() != 0) begin
                    o = order_q.pop_front();
                    check("grant_order_ls", 32'd1, 32'(o));
                end
            end
            prev_if_ack = if_ack;
            prev_ls_ack = ls_ack;
        end
    end

    task automatic backdoor(input logic [15:0] a, input logic [7:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    task automatic do_if(input logic [15:0] a, input logic [15:0] exp, input bit lat);
        exp_t e;
        int   n;
        bit   got;
        e.we = 1'b0;
        e.data = exp;
        if_q.push_back(e);
        if_addr = a;
        if_req  = 1'b1;
        n = 0;
        got = 0;
        while (!got && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (if_ack) got = 1;
        end
        if (!got) check("if_ack_timeout", 32'd0, 32'd1);
        else if (lat) check("if_latency", 32'(n), 32'd4);
        @(posedge clk);
        #1 if_req = 1'b0;
    endtask

    task automatic do_ls(input logic we, input logic [15:0] a, input logic [15:0] wd,
                         input logic [15:0] exp, input bit lat, input bit scramble);
        exp_t e;
        int   n;
        bit   got;
        e.we = we;
        e.data = exp;
        ls_q.push_back(e);
        ls_we    = we;
        ls_addr  = a;
        ls_wdata = wd;
        ls_req   = 1'b1;
        n = 0;
        got = 0;
        while (!got && n < 40) begin
            @(posedge clk);
            n++;
            if (scramble && n == 1) begin
                #1;
                ls_addr  = a ^ 16'h0F0F;
                ls_wdata = ~wd;
            end
            @(negedge clk);
            if (ls_ack) got = 1;
        end
        if (!got) check("ls_ack_timeout", 32'd0, 32'd1);
        else if (lat) check("ls_latency", 32'(n), 32'd4);
        @(posedge clk);
        #1 ls_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // Directed stimulus.
    initial begin
        int w0;
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;

        backdoor(16'h0010, 8'hAB);
        backdoor(16'h0011, 8'hCD);
        backdoor(16'h0040, 8'h11);
        backdoor(16'h0041, 8'h22);
        backdoor(16'h0050, 8'h33);
        backdoor(16'h0051, 8'h44);
        @(negedge clk);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_mem_cs",   32'(mem_cs),   32'd0);
        check("rst_mem_we",   32'(mem_we),   32'd0);
        check("rst_if_ack",   32'(if_ack),   32'd0);
        check("rst_ls_ack",   32'(ls_ack),   32'd0);
        check("rst_if_rdata", 32'(if_rdata), 32'd0);
        check("rst_ls_rdata", 32'(ls_rdata), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0;

        // Contention from reset: IF wins first, then strict alternation.
        order_q.push_back(1'b0);
        order_q.push_back(1'b1);
        order_q.push_back(1'b0);
        order_q.push_back(1'b1);
        fork
            begin
                do_if(16'h0040, 16'h1122, 1'b1);
                do_if(16'h0010, 16'hABCD, 1'b0);
            end
            begin
                do_ls(1'b0, 16'h0050, 16'h0000, 16'h3344, 1'b0, 1'b0);
                do_ls(1'b0, 16'h0040, 16'h0000, 16'h1122, 1'b0, 1'b0);
            end
        join
        check("order_drained", 32'(order_q.size()), 32'd0);
        @(negedge clk);

        // IF-only fetch never writes.
        w0 = we_cycles;
        do_if(16'h0010, 16'hABCD, 1'b1);
        check("fetch_no_we", 32'(we_cycles - w0), 32'd0);

        // Store then load back.
        do_ls(1'b1, 16'h0002, 16'h4020, 16'h0000, 1'b1, 1'b0);
        check("store_mem2", 32'(mem[2]), 32'h40);
        check("store_mem3", 32'(mem[3]), 32'h20);
        do_ls(1'b0, 16'h0002, 16'h0000, 16'h4020, 1'b1, 1'b0);
        // A store must leave the last loaded word on ls_rdata.
        do_ls(1'b1, 16'h0060, 16'h7788, 16'h0000, 1'b0, 1'b0);

        // Address wrap for the low byte.
        do_ls(1'b1, 16'hFFFF, 16'h1234, 16'h0000, 1'b0, 1'b0);
        check("wrap_mem_ffff", 32'(mem[16'hFFFF]), 32'h12);
        check("wrap_mem_0000", 32'(mem[0]), 32'h34);
        do_ls(1'b0, 16'hFFFF, 16'h0000, 16'h1234, 1'b0, 1'b0);

        // Inputs changed after the grant are ignored.
        do_ls(1'b1, 16'h0020, 16'h5AC3, 16'h0000, 1'b0, 1'b1);
        check("stable_mem20", 32'(mem[16'h0020]), 32'h5A);
        check("stable_mem21", 32'(mem[16'h0021]), 32'hC3);
        do_if(16'h0020, 16'h5AC3, 1'b0);

        // Reset during B1 of a store abandons it.
        ls_we = 1'b1; ls_addr = 16'h0100; ls_wdata = 16'hBEEF; ls_req = 1'b1;
        @(posedge clk);          // grant, B0 follows
        @(posedge clk);          // B1 follows
        #1 rst = 1'b1;
        @(negedge clk);
        check("midrst_in_b1_busy", 32'(busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy",   32'(busy),   32'd0);
        check("midrst_mem_cs", 32'(mem_cs), 32'd0);
        check("midrst_mem_we", 32'(mem_we), 32'd0);
        check("midrst_ls_ack", 32'(ls_ack), 32'd0);
        ls_req = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst_no_ack", 32'(ls_ack), 32'd0);
        end
        check("midrst_ls_rdata", 32'(ls_rdata), 32'd0);
        do_ls(1'b0, 16'h0010, 16'h0000, 16'hABCD, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        check("if_q_drained", 32'(if_q.size()), 32'd0);
        check("ls_q_drained", 32'(ls_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-wide system memory between the instruction fetch unit (IF, read-only) and the load/store unit (LS, read/write).
- Each requester issues 16-bit word accesses. The arbiter splits every word access into two sequential byte cycles and reassembles read data.
- It sits in `system`, between the CPU front end and the `memory` instance, and is the only driver of the memory's address, write-data and control pins.

Parameters:
- ADDR_W, 16, width of every address port.
- BYTE_W, 8, memory data width; word width is 2*BYTE_W.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  ADDR_W  fetch word address (byte address of the high byte).
- if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid this cycle.
- if_rdata  out  2*BYTE_W  fetched word.
- ls_req  in  1  load/store request; held high until ls_ack.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  ADDR_W  load/store word address.
- ls_wdata  in  2*BYTE_W  store data.
- ls_ack  out  1  one-cycle pulse: access complete; ls_rdata valid this cycle for loads.
- ls_rdata  out  2*BYTE_W  loaded word.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  BYTE_W  memory write byte.
- mem_rdata  in  BYTE_W  memory read byte, valid the cycle after mem_addr is presented with mem_cs=1, mem_we=0.
- mem_we  out  1  memory write enable.
- mem_cs  out  1  memory chip select.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; last_grant=LS, so IF wins the first tie.
  - All outputs 0, including if_rdata/ls_rdata and busy.
  - Reset mid-transaction abandons the access: no ack is issued; one byte of a store may already be written.
- Byte order is big-endian: word[15:8] at addr, word[7:0] at addr+1. addr+1 wraps modulo 2^ADDR_W (0xFFFF -> 0x0000).
- FSM states: IDLE -> B0 -> B1 -> CAP -> ACK -> IDLE. All memory outputs are registered (Moore).
- IDLE:
  - mem_cs=0.
  - On an edge with any req high, choose the owner.
  - Latch the owner's addr/we/wdata (IF forces we=0) and go to B0.
- Arbitration:
  - Only one requester high: it wins.
  - Both high: grant the requester that is not last_grant (round-robin); update last_grant on grant.
- B0: mem_cs=1, mem_addr=addr, mem_we=we, mem_wdata=wdata[15:8].
- B1:
  - mem_cs=1, mem_addr=addr+1, mem_we=we, mem_wdata=wdata[7:0].
  - For reads, capture mem_rdata into hi_byte.
- CAP: mem_cs=0, mem_we=0. For reads, capture mem_rdata into lo_byte.
- ACK:
  - Owner's ack=1 for exactly one cycle.
  - Owner's rdata={hi_byte,lo_byte} for loads/fetches; unchanged for stores.
  - The non-owner's ack and rdata are unchanged.
- Timing: a request sampled in IDLE at edge 0 produces ack high in the 4th cycle after it; IDLE lasts at least one cycle between accesses.
- Protocol:
  - A requester drops req on the edge that ends its ack cycle.
  - Inputs changing after the grant are ignored, since addr/we/wdata are latched.
- Never assert both acks in the same cycle. mem_we=1 only while mem_cs=1.
- Stores keep mem_wdata stable for the full cycle of each byte.

Test Plan:
- IF-only fetch: preload mem[0x0010]=0xAB, mem[0x0011]=0xCD; if_req with if_addr=0x0010 -> if_ack one cycle 4 cycles after grant, if_rdata=0xABCD, mem_we never 1.
- LS store: ls_we=1, ls_addr=0x0002, ls_wdata=0x4020 -> mem[2]=0x40, mem[3]=0x20; ls_ack single pulse; a later load of 0x0002 returns 0x4020.
- Contention: if_req and ls_req both high from reset and held, re-requesting after each ack -> grants alternate IF, LS, IF, LS; each ack goes to the matching owner, never overlapping.
- Wrap: LS store 0x1234 to 0xFFFF -> mem[0xFFFF]=0x12, mem[0x0000]=0x34; load back -> 0x1234.
- Reset mid-op: assert rst during B1 of an LS store -> next cycle state IDLE, mem_cs=0, busy=0, no ls_ack; a new request after reset completes normally.
- Input stability: change ls_addr/ls_wdata in the cycle after grant -> the original latched values are written.
